// File: rtl/mavg_param_if.sv
// Sample/result handshake bundle for the mavg_param moving-average filter.
// The master drives samples and window selection; the slave returns averages.
interface mavg_param_if #(
  parameter int W = 4
) ();
  logic [2:0]   len_sel;
  logic         in_valid;
  logic [W-1:0] x;
  logic         out_valid;
  logic [W-1:0] y;
  logic         primed;

  modport master (
    output len_sel,
    output in_valid,
    output x,
    input  out_valid,
    input  y,
    input  primed
  );

  modport slave (
    input  len_sel,
    input  in_valid,
    input  x,
    output out_valid,
    output y,
    output primed
  );
endinterface

// File: rtl/mavg_param.sv
// Parametrised moving-average filter: runtime window L = 2^min(len_sel, LOG2N),
// running-sum implementation with optional round-half-up and flush on length change.
module mavg_param #(
  parameter int W     = 4,
  parameter int LOG2N = 2,
  parameter int ROUND = 1
) (
  input  logic         clk,
  input  logic         reset,
  mavg_param_if.slave  bus
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = W + LOG2N;
  localparam int FW = LOG2N + 1;
  localparam int IW = (LOG2N > 0) ? LOG2N : 1;
  localparam logic [2:0] KMAX = 3'(LOG2N);

  logic [W-1:0]  tap_r [N];
  logic [SW-1:0] sum_r;
  logic [SW-1:0] sum_next_s;
  logic [FW-1:0] fill_r;
  logic [FW-1:0] fill_next_s;
  logic [FW-1:0] len_s;
  logic [2:0]    k_r;
  logic [2:0]    k_clamp_s;
  logic          flush_s;
  logic [IW-1:0] old_idx_s;
  logic [W-1:0]  tap_old_s;
  logic [SW:0]   rnd_s;
  logic [W-1:0]  y_r;
  logic [W-1:0]  y_next_s;
  logic          out_valid_r;
  logic          primed_r;
  logic          primed_next_s;

  // Window decode, flush detection and the sample leaving the active window.
  always_comb begin
    if (bus.len_sel > KMAX) begin
      k_clamp_s = KMAX;
    end else begin
      k_clamp_s = bus.len_sel;
    end
    flush_s   = (k_clamp_s != k_r);
    len_s     = FW'(1) << k_clamp_s;
    old_idx_s = IW'((8'd1 << k_r) - 8'd1);
    tap_old_s = tap_r[old_idx_s];
  end

  // Next running sum, fill level, primed flag and rounded average.
  always_comb begin
    sum_next_s    = sum_r;
    fill_next_s   = fill_r;
    primed_next_s = primed_r;
    rnd_s         = {(SW+1){1'b0}};

    // A flush starts an empty window; a same-edge sample becomes its first entry.
    if (flush_s) begin
      if (bus.in_valid) begin
        sum_next_s  = SW'(bus.x);
        fill_next_s = FW'(1);
      end else begin
        sum_next_s  = {SW{1'b0}};
        fill_next_s = {FW{1'b0}};
      end
    end else if (bus.in_valid) begin
      sum_next_s = sum_r + SW'(bus.x) - SW'(tap_old_s);
      if (fill_r != len_s) begin
        fill_next_s = fill_r + FW'(1);
      end else begin
        fill_next_s = fill_r;
      end
    end else begin
      sum_next_s  = sum_r;
      fill_next_s = fill_r;
    end

    if (flush_s) begin
      primed_next_s = 1'b0;
    end else begin
      primed_next_s = primed_r | (fill_next_s == len_s);
    end

    if ((ROUND != 0) && (k_clamp_s != 3'd0)) begin
      rnd_s = (SW+1)'(1) << (k_clamp_s - 3'd1);
    end else begin
      rnd_s = {(SW+1){1'b0}};
    end

    // Divisor is always L, so the average ramps up while the window fills.
    y_next_s = W'(({1'b0, sum_next_s} + rnd_s) >> k_clamp_s);
  end

  // Sample delay line; cleared on flush so a later length increase sees zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        tap_r[i] <= {W{1'b0}};
      end
    end else if (flush_s) begin
      for (int i = 1; i < N; i++) begin
        tap_r[i] <= {W{1'b0}};
      end
      tap_r[0] <= bus.in_valid ? bus.x : {W{1'b0}};
    end else if (bus.in_valid) begin
      for (int i = N - 1; i > 0; i--) begin
        tap_r[i] <= tap_r[i-1];
      end
      tap_r[0] <= bus.x;
    end else begin
      for (int i = 0; i < N; i++) begin
        tap_r[i] <= tap_r[i];
      end
    end
  end

  // Running state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_r         <= k_clamp_s;
      sum_r       <= {SW{1'b0}};
      fill_r      <= {FW{1'b0}};
      primed_r    <= 1'b0;
      out_valid_r <= 1'b0;
      y_r         <= {W{1'b0}};
    end else begin
      k_r         <= k_clamp_s;
      sum_r       <= sum_next_s;
      fill_r      <= fill_next_s;
      primed_r    <= primed_next_s;
      out_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        y_r <= y_next_s;
      end else begin
        y_r <= y_r;
      end
    end
  end

  assign bus.y         = y_r;
  assign bus.out_valid = out_valid_r;
  assign bus.primed    = primed_r;

endmodule

// File: tb/tb_mavg_param.sv
// Directed scoreboard bench for mavg_param: a ROUND=1 and a ROUND=0 instance
// share the same stimulus; expectations are queued at drive time, popped after the edge.
module tb_mavg_param;

  logic clk = 1'b0;
  logic reset;

  mavg_param_if #(.W(4)) bus1 ();
  mavg_param_if #(.W(4)) bus0 ();

  mavg_param #(.W(4), .LOG2N(2), .ROUND(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  mavg_param #(.W(4), .LOG2N(2), .ROUND(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  assign bus0.len_sel  = bus1.len_sel;
  assign bus0.in_valid = bus1.in_valid;
  assign bus0.x        = bus1.x;

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] y;
    logic       ov;
    logic       pr;
    logic       chk0;
    logic [3:0] y0;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic step(input string tag, input logic rst, input logic [2:0] ls,
                      input logic v, input logic [3:0] xv,
                      input logic [3:0] ey, input logic eov, input logic epr,
                      input logic c0, input logic [3:0] ey0);
    exp_t e;
    exp_t got;
    reset         = rst;
    bus1.len_sel  = ls;
    bus1.in_valid = v;
    bus1.x        = xv;
    e.tag = tag; e.y = ey; e.ov = eov; e.pr = epr; e.chk0 = c0; e.y0 = ey0;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    checks++;
    assert (bus1.y === got.y) else begin
      errors++;
      $error("FAIL %s y: observed %0d expected %0d", got.tag, bus1.y, got.y);
    end
    checks++;
    assert (bus1.out_valid === got.ov) else begin
      errors++;
      $error("FAIL %s out_valid: observed %0b expected %0b", got.tag, bus1.out_valid, got.ov);
    end
    checks++;
    assert (bus1.primed === got.pr) else begin
      errors++;
      $error("FAIL %s primed: observed %0b expected %0b", got.tag, bus1.primed, got.pr);
    end
    if (got.chk0) begin
      checks++;
      assert (bus0.y === got.y0) else begin
        errors++;
        $error("FAIL %s y_trunc: observed %0d expected %0d", got.tag, bus0.y, got.y0);
      end
    end
  endtask

  logic [3:0] up_r1 [6] = '{4'd4, 4'd8, 4'd11, 4'd15, 4'd15, 4'd15};
  logic [3:0] dn_r1 [6] = '{4'd11, 4'd8, 4'd4, 4'd0, 4'd0, 4'd0};
  logic [3:0] up_r0 [6] = '{4'd3, 4'd7, 4'd11, 4'd15, 4'd15, 4'd15};
  logic [3:0] dn_r0 [6] = '{4'd11, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0};

  initial begin
    // Reset for three cycles with a valid sample pending: reset dominates.
    for (int i = 0; i < 3; i++) begin
      step("reset", 1'b1, 3'd2, 1'b1, 4'hF, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    end

    // Fill ramp, both rounding modes.
    for (int i = 0; i < 6; i++) begin
      step("fill", 1'b0, 3'd2, 1'b1, 4'hF, up_r1[i], 1'b1, (i >= 3), 1'b1, up_r0[i]);
    end
    for (int i = 0; i < 6; i++) begin
      step("drain", 1'b0, 3'd2, 1'b1, 4'h0, dn_r1[i], 1'b1, 1'b1, 1'b1, dn_r0[i]);
    end

    // Repeated square wave: no drift in the running sum.
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 6; i++) begin
        step("rep_hi", 1'b0, 3'd2, 1'b1, 4'hF, up_r1[i], 1'b1, 1'b1, 1'b1, up_r0[i]);
      end
      for (int i = 0; i < 6; i++) begin
        step("rep_lo", 1'b0, 3'd2, 1'b1, 4'h0, dn_r1[i], 1'b1, 1'b1, 1'b1, dn_r0[i]);
      end
    end

    // Gapped input with L=2: state advances only on valid cycles.
    step("gap_rst", 1'b1, 3'd1, 1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    step("gap_v1", 1'b0, 3'd1, 1'b1, 4'hF, 4'd8, 1'b1, 1'b0, 1'b1, 4'd7);
    step("gap_h1", 1'b0, 3'd1, 1'b0, 4'hF, 4'd8, 1'b0, 1'b0, 1'b1, 4'd7);
    step("gap_v2", 1'b0, 3'd1, 1'b1, 4'hF, 4'd15, 1'b1, 1'b1, 1'b1, 4'd15);
    step("gap_h2", 1'b0, 3'd1, 1'b0, 4'hF, 4'd15, 1'b0, 1'b1, 1'b0, 4'd0);
    step("gap_v3", 1'b0, 3'd1, 1'b1, 4'hF, 4'd15, 1'b1, 1'b1, 1'b0, 4'd0);

    // Length change flush with a same-edge sample, then clamp behaviour.
    step("fl_rst", 1'b1, 3'd2, 1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      step("fl_fill", 1'b0, 3'd2, 1'b1, 4'hF, up_r1[i], 1'b1, (i == 3), 1'b0, 4'd0);
    end
    step("fl_to0", 1'b0, 3'd0, 1'b1, 4'h5, 4'd5, 1'b1, 1'b0, 1'b1, 4'd5);
    step("fl_prim", 1'b0, 3'd0, 1'b0, 4'h0, 4'd5, 1'b0, 1'b1, 1'b0, 4'd0);
    step("fl_to7", 1'b0, 3'd7, 1'b0, 4'h0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0);
    step("fl_s1", 1'b0, 3'd7, 1'b1, 4'hF, 4'd4, 1'b1, 1'b0, 1'b1, 4'd3);
    step("noflush", 1'b0, 3'd3, 1'b1, 4'hF, 4'd8, 1'b1, 1'b0, 1'b1, 4'd7);
    step("nf_s3", 1'b0, 3'd3, 1'b1, 4'hF, 4'd11, 1'b1, 1'b0, 1'b0, 4'd0);
    step("nf_s4", 1'b0, 3'd3, 1'b1, 4'hF, 4'd15, 1'b1, 1'b1, 1'b0, 4'd0);

    // Mid-stream reset (sum at 60) discards history.
    step("mid_rst", 1'b1, 3'd3, 1'b1, 4'hF, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    step("post_rst", 1'b0, 3'd2, 1'b1, 4'hF, 4'd4, 1'b1, 1'b0, 1'b1, 4'd3);
    step("post_r2", 1'b0, 3'd2, 1'b1, 4'hF, 4'd8, 1'b1, 1'b0, 1'b1, 4'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
